// File: rtl/systolic_ctrl.sv
// systolic_ctrl
//
// Sequencing controller for a 3x3 output-stationary systolic array of
// binary16 PEs. Operand matrices A and B are loaded through a write port
// while idle. A run clears the array accumulators, streams skewed A rows into
// the left edge and B columns into the top edge, drains the pipeline and
// captures the nine PE results into a readable buffer. The controller does no
// arithmetic: every element passes through bit-exact.
//
// Ports
//   clock    : rising-edge clock
//   reset    : synchronous, active-high
//   start    : run request, honoured only while idle
//   wr_en    : operand write strobe (idle only, wr_addr 0..8)
//   wr_sel   : 0 = matrix A, 1 = matrix B
//   wr_addr  : row-major element index (3*row + col)
//   wr_data  : element value
//   rd_addr  : row-major result index
//   rd_data  : result buffer element, combinational, 0 for rd_addr > 8
//   a_row    : left-edge operands, slice i drives array row i
//   b_col    : top-edge operands, slice j drives array column j
//   acc_clr  : array forces the PE accumulate input to zero while high
//   res_in   : PE outputs, slice 3*i+j is PE(i,j)
//   busy     : high while a run is in progress
//   done     : one-cycle pulse, result buffer freshly captured
module systolic_ctrl #(
  parameter int W = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           wr_en,
  input  logic           wr_sel,
  input  logic [3:0]     wr_addr,
  input  logic [W-1:0]   wr_data,
  input  logic [3:0]     rd_addr,
  output logic [W-1:0]   rd_data,
  output logic [3*W-1:0] a_row,
  output logic [3*W-1:0] b_col,
  output logic           acc_clr,
  input  logic [9*W-1:0] res_in,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FEED    = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  // Last value of t in each timed state. FEED counts 0..4 and DRAIN
  // carries on from 5 to 6, so one counter covers both.
  localparam logic [2:0] T_CLEAR_LAST = 3'd2;
  localparam logic [2:0] T_FEED_LAST  = 3'd4;
  localparam logic [2:0] T_DRAIN_LAST = 3'd6;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] t;
  logic [2:0] t_nxt;

  logic [W-1:0] mat_a   [9];
  logic [W-1:0] mat_b   [9];
  logic [W-1:0] res_buf [9];

  // Next-cycle values of the registered edge/status outputs.
  logic [3*W-1:0] a_row_nxt;
  logic [3*W-1:0] b_col_nxt;
  logic           acc_clr_nxt;
  logic           busy_nxt;
  logic           done_nxt;

  logic           wr_ok;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      t     <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      S_IDLE: begin
        t_nxt = '0;
        if (start) begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (t == T_CLEAR_LAST) begin
          state_nxt = S_FEED;
          t_nxt     = '0;
        end else begin
          t_nxt = t + 3'd1;
        end
      end
      S_FEED: begin
        // Falls straight into DRAIN with t=5.
        if (t == T_FEED_LAST) begin
          state_nxt = S_DRAIN;
        end
        t_nxt = t + 3'd1;
      end
      S_DRAIN: begin
        if (t == T_DRAIN_LAST) begin
          state_nxt = S_CAPTURE;
          t_nxt     = '0;
        end else begin
          t_nxt = t + 3'd1;
        end
      end
      S_CAPTURE: begin
        state_nxt = S_IDLE;
        t_nxt     = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic: decoded from the upcoming state so the registered edges
  // line up with the state they belong to.
  // ---------------------------------------------------------------------
  always_comb begin
    a_row_nxt   = '0;
    b_col_nxt   = '0;
    acc_clr_nxt = (state_nxt == S_CLEAR);
    busy_nxt    = (state_nxt != S_IDLE);
    done_nxt    = (state == S_CAPTURE);
    if (state_nxt == S_FEED) begin
      // Skewed injection: row i lags by i cycles, so at step t it carries
      // A[i][t-i] (flat index 3i + t - i = 2i + t). Column j likewise
      // carries B[t-j][j] (flat index 3(t-j) + j = 3t - 2j).
      for (int i = 0; i < 3; i++) begin
        if ((int'(t_nxt) >= i) && (int'(t_nxt) - i <= 2)) begin
          a_row_nxt[i*W +: W] = mat_a[4'(2*i + int'(t_nxt))];
        end
      end
      for (int j = 0; j < 3; j++) begin
        if ((int'(t_nxt) >= j) && (int'(t_nxt) - j <= 2)) begin
          b_col_nxt[j*W +: W] = mat_b[4'(3*int'(t_nxt) - 2*j)];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      a_row   <= '0;
      b_col   <= '0;
      acc_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      a_row   <= a_row_nxt;
      b_col   <= b_col_nxt;
      acc_clr <= acc_clr_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Operand storage. A write coinciding with start still commits, because
  // the matrices are first read when FEED begins three cycles later.
  // ---------------------------------------------------------------------
  assign wr_ok = wr_en && (state == S_IDLE) && (wr_addr <= 4'd8);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 9; k++) begin
        mat_a[k] <= '0;
        mat_b[k] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel) begin
        mat_b[wr_addr] <= wr_data;
      end else begin
        mat_a[wr_addr] <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Result buffer: loaded on the edge that ends CAPTURE, held otherwise.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 9; k++) begin
        res_buf[k] <= '0;
      end
    end else if (state == S_CAPTURE) begin
      for (int k = 0; k < 9; k++) begin
        res_buf[k] <= res_in[k*W +: W];
      end
    end
  end

  assign rd_data = (rd_addr <= 4'd8) ? res_buf[rd_addr] : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl. Contains a small behavioural model of the 3x3
// output-stationary PE array (integer-valued binary16 only) driven by the
// controller's edge outputs, so wrong skew or clearing shows up as wrong
// results. Expected results are hand-computed constants.
module tb_systolic_ctrl;
  localparam int W = 16;

  logic           clock   = 1'b0;
  logic           reset   = 1'b1;
  logic           start   = 1'b0;
  logic           wr_en   = 1'b0;
  logic           wr_sel  = 1'b0;
  logic [3:0]     wr_addr = '0;
  logic [W-1:0]   wr_data = '0;
  logic [3:0]     rd_addr = '0;
  logic [W-1:0]   rd_data;
  logic [3*W-1:0] a_row;
  logic [3*W-1:0] b_col;
  logic           acc_clr;
  logic [9*W-1:0] res_in;
  logic           busy;
  logic           done;

  int n_vec = 0;
  int n_err = 0;

  logic [3*W-1:0] a_tr [0:40];
  logic [3*W-1:0] b_tr [0:40];

  systolic_ctrl #(.W(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .wr_en  (wr_en),
    .wr_sel (wr_sel),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .a_row  (a_row),
    .b_col  (b_col),
    .acc_clr(acc_clr),
    .res_in (res_in),
    .busy   (busy),
    .done   (done)
  );

  always #20 clock = ~clock;

  // binary16 <-> integer for small non-negative integers.
  function automatic int h2i(input logic [15:0] h);
    int e;
    int m;
    if (h[14:10] == 5'd0) return 0;
    e = int'(h[14:10]) - 15;
    m = 1024 + int'(h[9:0]);
    if (e < 0 || e > 10) return 0;
    return m >> (10 - e);
  endfunction

  function automatic logic [15:0] i2h(input int n);
    int e;
    int m;
    if (n <= 0) return 16'h0000;
    e = 0;
    for (int k = 0; k < 16; k++) begin
      if (((n >> k) & 1) == 1) e = k;
    end
    if (e <= 10) m = (n << (10 - e)) & 1023;
    else         m = (n >> (e - 10)) & 1023;
    return {1'b0, 5'(e + 15), 10'(m)};
  endfunction

  // PE array model: pass-through registers start with junk so that an
  // incomplete flush would corrupt results of the first run.
  int ar  [3][3] = '{default: 5};
  int br  [3][3] = '{default: 5};
  int acc [3][3] = '{default: 77};
  int ai;
  int bi;

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (j == 0) ai = h2i(a_row[i*W +: W]);
        else        ai = ar[i][j-1];
        if (i == 0) bi = h2i(b_col[j*W +: W]);
        else        bi = br[i-1][j];
        ar[i][j]  <= ai;
        br[i][j]  <= bi;
        acc[i][j] <= (acc_clr ? 0 : acc[i][j]) + ai * bi;
      end
    end
  end

  always_comb begin
    res_in = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        res_in[(3*i+j)*W +: W] = i2h(acc[i][j]);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load(input logic sel, input logic [143:0] vals);
    for (int k = 0; k < 9; k++) wr(sel, 4'(k), vals[k*16 +: 16]);
  endtask

  task automatic check_res(input string tag, input logic [143:0] e);
    for (int k = 0; k < 9; k++) begin
      rd_addr = 4'(k);
      #1;
      check($sformatf("%s rd[%0d]", tag, k), rd_data, e[k*16 +: 16]);
    end
    rd_addr = 4'd9;
    #1;
    check({tag, " rd[9]"}, rd_data, 0);
    rd_addr = 4'd15;
    #1;
    check({tag, " rd[15]"}, rd_data, 0);
  endtask

  // Issues start in the current cycle and returns in the done cycle.
  // inj marks busy cycles in which a write of 4000 to A[0] is attempted.
  task automatic do_run(input string tag, input logic [15:0] inj);
    int c;
    int clr;
    int bad;
    clr = 0;
    bad = 0;
    start = 1'b1;
    tick();
    c = 1;
    start = 1'b0;
    wr_en = 1'b0;
    while (1) begin
      a_tr[c] = a_row;
      b_tr[c] = b_col;
      if (acc_clr) clr++;
      if (done || c >= 40) break;
      if (busy !== (c <= 11)) bad++;
      if (c < 16 && inj[c]) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'h4000;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      c++;
    end
    wr_en = 1'b0;
    check({tag, " latency"}, c, 12);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " busy profile errs"}, bad, 0);
    check({tag, " acc_clr cycles"}, clr, 3);
  endtask

  logic [143:0] ident = {16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h3C00,
                         16'h0000, 16'h0000, 16'h0000, 16'h3C00};
  logic [143:0] b19   = {16'h4880, 16'h4800, 16'h4700, 16'h4600, 16'h4500,
                         16'h4400, 16'h4200, 16'h4000, 16'h3C00};
  logic [143:0] r_b2b = {16'h4400, 16'h4200, 16'h4200, 16'h4400, 16'h4200,
                         16'h4200, 16'h4400, 16'h4200, 16'h4200};

  int n_done;
  int n_clr;
  int dc;
  int cyc;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst a_row", a_row, 0);
    check("rst b_col", b_col, 0);
    check("rst acc_clr", acc_clr, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    rd_addr = 4'd4;
    #1;
    check("rst rd_data", rd_data, 0);

    // Identity times B; writes during CLEAR and FEED must be ignored.
    load(1'b0, ident);
    load(1'b1, b19);
    do_run("ident", 16'b0000_0000_0010_0100);
    check_res("ident", b19);
    tick();

    // Out-of-range addresses leave A and B intact.
    wr(1'b0, 4'd12, 16'h4000);
    wr(1'b1, 4'd9, 16'h4000);
    do_run("ident2", 16'h0000);
    check_res("ident2", b19);
    tick();

    // All ones times all twos, with edge-skew checks.
    load(1'b0, {9{16'h3C00}});
    load(1'b1, {9{16'h4000}});
    do_run("ones", 16'h0000);
    check("skew a t0", a_tr[4], 48'h0000_0000_3C00);
    check("skew a t2", a_tr[6], 48'h3C00_3C00_3C00);
    check("skew a t4", a_tr[8], 48'h3C00_0000_0000);
    check("skew b t1", b_tr[5], 48'h0000_4000_4000);
    check("skew drain", a_tr[9], 0);
    check_res("ones", {9{16'h4600}});
    tick();

    // Back-to-back: B all ones, then restart in the done cycle together
    // with a write B[2][2] = 2.0 that the second run must see.
    load(1'b1, {9{16'h3C00}});
    do_run("b2b1", 16'h0000);
    check_res("b2b1", {9{16'h4200}});
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd8; wr_data = 16'h4000;
    do_run("b2b2", 16'h0000);
    check_res("b2b2", r_b2b);
    tick();

    // Reset in cycle 6 of a run.
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 6) begin tick(); cyc++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst busy", busy, 0);
    check("midrst a_row", a_row, 0);
    check("midrst b_col", b_col, 0);
    check("midrst acc_clr", acc_clr, 0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) n_done++;
      tick();
    end
    check("midrst done pulses", n_done, 0);
    check_res("midrst", {9{16'h0000}});

    // Fresh run after reset (matrices were cleared by reset).
    load(1'b0, {9{16'h3C00}});
    load(1'b1, {9{16'h4000}});
    do_run("fresh", 16'h0000);
    check_res("fresh", {9{16'h4600}});
    tick();

    // start held for three cycles gives one run.
    load(1'b1, {9{16'h3C00}});
    n_done = 0;
    n_clr = 0;
    dc = 0;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 3) start = 1'b0;
      if (done) begin n_done++; dc = c; end
      if (acc_clr) n_clr++;
    end
    check("held done pulses", n_done, 1);
    check("held done cycle", dc, 12);
    check("held acc_clr cycles", n_clr, 3);
    check_res("held", {9{16'h4200}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
